// File: rtl/obi_pkg.sv
// rtl/obi_pkg.sv - shared constants and state encoding for the OBI byte-enable master
//
// Contents:
//   OBI_ADDR_WIDTH / OBI_DATA_WIDTH  default bus widths
//   OBI_TIMEOUT                      default response wait limit in cycles
//   ERR_DATA                         read data reported on locally generated errors
//   obi_state_t, ST_*                master FSM state encoding
package obi_pkg;

  localparam int OBI_ADDR_WIDTH = 32;
  localparam int OBI_DATA_WIDTH = 32;
  localparam int OBI_TIMEOUT    = 16;

  localparam logic [31:0] ERR_DATA = 32'hBADCAB1E;

  typedef logic [1:0] obi_state_t;

  localparam obi_state_t ST_IDLE = 2'd0;
  localparam obi_state_t ST_ADDR = 2'd1;
  localparam obi_state_t ST_RESP = 2'd2;
  localparam obi_state_t ST_DONE = 2'd3;

endpackage

// File: rtl/obi_timeout_cnt.sv
// rtl/obi_timeout_cnt.sv - response wait counter for the OBI master
//
// Ports:
//   clk_i      clock, rising edge
//   reset_ni   synchronous active-low reset
//   clear_i    forces the count back to zero
//   enable_i   counts one elapsed cycle
//   expired_o  high while the current enabled cycle is the LIMIT-th one
//
// LIMIT must be at least 2 so the count can hold LIMIT-1.
module obi_timeout_cnt #(
  parameter int LIMIT = 16
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;

  // The count equals the number of enabled cycles already elapsed, so the
  // LIMIT-th enabled cycle sees LIMIT-1 here.
  assign expired_o = (cnt_q == CW'(LIMIT - 1));

  always_ff @(posedge clk_i) begin
    if (!reset_ni || clear_i) begin
      cnt_q <= '0;
    end else if (enable_i && !expired_o) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/obi_master_be.sv
// rtl/obi_master_be.sv - single-outstanding OBI master with byte enables
//
// Ports:
//   clk_i, reset_ni                     clock, synchronous active-low reset
//   ctrl_req_i / ctrl_ready_o           command handshake (ready only in IDLE)
//   ctrl_addr_i, ctrl_we_i, ctrl_be_i,
//   ctrl_wdata_i                        command fields, registered on accept
//   ctrl_rvalid_o, ctrl_rdata_o,
//   ctrl_err_o                          one-cycle completion with data and error
//   obi_req_o / obi_gnt_i               OBI address-phase handshake
//   obi_addr_o, obi_we_o, obi_be_o,
//   obi_wdata_o                         OBI address-phase payload
//   obi_rvalid_i / obi_rready_o         OBI response handshake
//   obi_rdata_i, obi_err_i              OBI response payload
module obi_master_be
  import obi_pkg::*;
#(
  parameter int ADDR_WIDTH = OBI_ADDR_WIDTH,
  parameter int DATA_WIDTH = OBI_DATA_WIDTH,
  parameter int TIMEOUT    = OBI_TIMEOUT
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,

  input  logic                    ctrl_req_i,
  output logic                    ctrl_ready_o,
  input  logic [ADDR_WIDTH-1:0]   ctrl_addr_i,
  input  logic                    ctrl_we_i,
  input  logic [DATA_WIDTH/8-1:0] ctrl_be_i,
  input  logic [DATA_WIDTH-1:0]   ctrl_wdata_i,
  output logic                    ctrl_rvalid_o,
  output logic [DATA_WIDTH-1:0]   ctrl_rdata_o,
  output logic                    ctrl_err_o,

  output logic                    obi_req_o,
  input  logic                    obi_gnt_i,
  output logic [ADDR_WIDTH-1:0]   obi_addr_o,
  output logic                    obi_we_o,
  output logic [DATA_WIDTH/8-1:0] obi_be_o,
  output logic [DATA_WIDTH-1:0]   obi_wdata_o,
  input  logic                    obi_rvalid_i,
  output logic                    obi_rready_o,
  input  logic [DATA_WIDTH-1:0]   obi_rdata_i,
  input  logic                    obi_err_i
);

  localparam logic [DATA_WIDTH-1:0] ERR_WORD = DATA_WIDTH'(ERR_DATA);

  obi_state_t              state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    we_q;
  logic [DATA_WIDTH/8-1:0] be_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    err_q;

  logic in_idle;
  logic in_addr;
  logic in_resp;
  logic in_done;
  logic tmo_enable;
  logic tmo_expired;

  assign in_idle = (state_q == ST_IDLE);
  assign in_addr = (state_q == ST_ADDR);
  assign in_resp = (state_q == ST_RESP);
  assign in_done = (state_q == ST_DONE);

  // Ready is held low while reset is asserted so it only rises once the
  // master is actually out of reset.
  assign ctrl_ready_o = in_idle & reset_ni;

  // Payload is zero outside the address phase; write data is masked on reads.
  assign obi_req_o    = in_addr;
  assign obi_addr_o   = in_addr ? addr_q : '0;
  assign obi_we_o     = in_addr & we_q;
  assign obi_be_o     = in_addr ? be_q : '0;
  assign obi_wdata_o  = (in_addr && we_q) ? wdata_q : '0;
  assign obi_rready_o = in_resp;

  assign ctrl_rvalid_o = in_done;
  assign ctrl_rdata_o  = in_done ? rdata_q : '0;
  assign ctrl_err_o    = in_done & err_q;

  // The counter starts on the grant edge so its value is the number of
  // cycles since grant; expiry lands the completion TIMEOUT cycles after it.
  assign tmo_enable = in_resp | (in_addr & obi_gnt_i);

  obi_timeout_cnt #(
    .LIMIT (TIMEOUT)
  ) u_timeout_cnt (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .clear_i   (~tmo_enable),
    .enable_i  (tmo_enable),
    .expired_o (tmo_expired)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ctrl_req_i) begin
            addr_q  <= ctrl_addr_i;
            we_q    <= ctrl_we_i;
            be_q    <= ctrl_be_i;
            wdata_q <= ctrl_wdata_i;
            if (ctrl_addr_i[1:0] != 2'b00) begin
              // Misaligned: complete locally, never touch the bus.
              state_q <= ST_DONE;
              rdata_q <= ERR_WORD;
              err_q   <= 1'b1;
            end else begin
              state_q <= ST_ADDR;
              rdata_q <= '0;
              err_q   <= 1'b0;
            end
          end
        end
        ST_ADDR: begin
          if (obi_gnt_i) begin
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (obi_rvalid_i) begin
            // Clean writes report zero data; errored responses pass data on.
            rdata_q <= (we_q && !obi_err_i) ? '0 : obi_rdata_i;
            err_q   <= obi_err_i;
            state_q <= ST_DONE;
          end else if (tmo_expired) begin
            rdata_q <= ERR_WORD;
            err_q   <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
